// File: rtl/pulse_gate_counter.sv
// Per-channel click counter over a fixed gate window. Each completed window is
// snapshotted into a shadow bank and streamed out one word per channel over valid/ready.
module pulse_gate_counter #(
    parameter int N_CH        = 8,
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 24,
    parameter int GATE_CYCLES = 1000000,
    parameter int WIN_W       = 16,
    localparam int CH_W       = $clog2(N_CH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [N_CH-1:0]   clicks,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_channel,
    output logic [CNT_W-1:0]  out_count,
    output logic [WIN_W-1:0]  out_window,
    output logic              out_last,
    output logic              dropped
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [GATE_W-1:0] GATE_END = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1'b1);
    localparam logic [WIN_W-1:0]  WIN_ONE  = WIN_W'(1'b1);
    localparam logic [CH_W-1:0]   CH_ONE   = CH_W'(1'b1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(N_CH - 1);

    typedef enum logic {
        GATE_IDLE  = 1'b0,
        GATE_COUNT = 1'b1
    } gate_state_t;

    typedef enum logic {
        RD_EMPTY = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_t;

    // Counters hold at full scale instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic click);
        logic [CNT_W-1:0] result;
        if (click && (value != CNT_MAX)) begin
            result = value + CNT_ONE;
        end else begin
            result = value;
        end
        return result;
    endfunction

    gate_state_t      gate_state_r;
    rd_state_t        rd_state_r;
    logic [GATE_W-1:0] timer_r;
    logic [WIN_W-1:0] win_r;
    logic [CNT_W-1:0] live_r   [N_CH];
    logic [CNT_W-1:0] shadow_r [N_CH];
    logic [CNT_W-1:0] total_s  [N_CH];
    logic             window_end_s;
    logic             snapshot_s;
    logic             xfer_s;
    logic [CH_W-1:0]  next_ch_s;

    // Window totals include the click arriving on the window-end cycle itself.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            total_s[i] = sat_inc(live_r[i], clicks[i]);
        end
        window_end_s = (gate_state_r == GATE_COUNT) && enable && (timer_r == GATE_END);
        snapshot_s   = window_end_s && (rd_state_r == RD_EMPTY);
        xfer_s       = out_valid && out_ready;
        next_ch_s    = out_channel + CH_ONE;
    end

    // Gate FSM: live bank, window timer, window index and sticky drop flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gate_state_r <= GATE_IDLE;
            timer_r      <= '0;
            win_r        <= '0;
            dropped      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                live_r[i] <= '0;
            end
        end else begin
            case (gate_state_r)
                GATE_IDLE: begin
                    if (enable) begin
                        gate_state_r <= GATE_COUNT;
                        timer_r      <= '0;
                        for (int i = 0; i < N_CH; i++) begin
                            live_r[i] <= '0;
                        end
                    end else begin
                        gate_state_r <= GATE_IDLE;
                    end
                end
                GATE_COUNT: begin
                    if (!enable) begin
                        // Partial window is abandoned; index is left untouched.
                        gate_state_r <= GATE_IDLE;
                        timer_r      <= '0;
                    end else if (window_end_s) begin
                        timer_r <= '0;
                        win_r   <= win_r + WIN_ONE;
                        if (!snapshot_s) begin
                            dropped <= 1'b1;
                        end
                        for (int i = 0; i < N_CH; i++) begin
                            live_r[i] <= '0;
                        end
                    end else begin
                        timer_r <= timer_r + GATE_ONE;
                        for (int i = 0; i < N_CH; i++) begin
                            live_r[i] <= total_s[i];
                        end
                    end
                end
                default: begin
                    gate_state_r <= GATE_IDLE;
                    timer_r      <= '0;
                end
            endcase
        end
    end

    // Readout FSM: shadow bank capture and the valid/ready word stream.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_r  <= RD_EMPTY;
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_count   <= '0;
            out_window  <= '0;
            out_last    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                shadow_r[i] <= '0;
            end
        end else begin
            case (rd_state_r)
                RD_EMPTY: begin
                    if (snapshot_s) begin
                        rd_state_r  <= RD_DRAIN;
                        out_valid   <= 1'b1;
                        out_channel <= '0;
                        out_count   <= total_s[0];
                        out_window  <= win_r;
                        out_last    <= 1'b0;
                        for (int i = 0; i < N_CH; i++) begin
                            shadow_r[i] <= total_s[i];
                        end
                    end
                end
                RD_DRAIN: begin
                    if (xfer_s) begin
                        if (out_last) begin
                            rd_state_r  <= RD_EMPTY;
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            out_channel <= '0;
                            out_count   <= '0;
                        end else begin
                            out_channel <= next_ch_s;
                            out_count   <= shadow_r[next_ch_s];
                            out_last    <= (next_ch_s == LAST_CH);
                        end
                    end
                end
                default: begin
                    rd_state_r <= RD_EMPTY;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_gate_counter.sv
// Randomized scoreboard bench for pulse_gate_counter with a window-level reference
// model, plus a second small-counter instance exercising saturation.
module tb_pulse_gate_counter;

    localparam int N       = 4;
    localparam int G       = 16;
    localparam int CNT_MAX = 255;

    typedef struct {
        int ch;
        int cnt;
        int win;
        int last;
    } word_t;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic [N-1:0] clicks;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_channel;
    logic [7:0]  out_count;
    logic [15:0] out_window;
    logic        out_last;
    logic        dropped;

    logic        s_enable;
    logic [3:0]  s_clicks;
    logic        s_ready;
    logic        s_out_valid;
    logic [1:0]  s_out_channel;
    logic [3:0]  s_out_count;
    logic [15:0] s_out_window;
    logic        s_out_last;
    logic        s_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    word_t exp_q[$];
    int    m_tot[N];
    bit    m_run;
    int    m_t;
    int    m_win;
    int    m_busy;
    int    m_drop;

    pulse_gate_counter #(.N_CH(4), .CNT_W(8), .GATE_W(24), .GATE_CYCLES(G), .WIN_W(16)) u_dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clicks(clicks),
        .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
        .out_count(out_count), .out_window(out_window), .out_last(out_last),
        .dropped(dropped)
    );

    pulse_gate_counter #(.N_CH(4), .CNT_W(4), .GATE_W(24), .GATE_CYCLES(32), .WIN_W(16)) u_sat (
        .clock(clock), .reset_n(reset_n), .enable(s_enable), .clicks(s_clicks),
        .out_valid(s_out_valid), .out_ready(s_ready), .out_channel(s_out_channel),
        .out_count(s_out_count), .out_window(s_out_window), .out_last(s_out_last),
        .dropped(s_dropped)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-window totals, drain as a count of outstanding words.
    task automatic model_step();
        bit    was_empty;
        word_t w;
        if (!reset_n) begin
            m_run  = 1'b0;
            m_t    = 0;
            m_win  = 0;
            m_busy = 0;
            m_drop = 0;
            foreach (m_tot[i]) m_tot[i] = 0;
            exp_q.delete();
        end else begin
            was_empty = (m_busy == 0);
            if (m_busy > 0 && out_ready) m_busy--;
            if (!m_run) begin
                if (enable) begin
                    m_run = 1'b1;
                    m_t   = 0;
                    foreach (m_tot[i]) m_tot[i] = 0;
                end
            end else if (!enable) begin
                m_run = 1'b0;
            end else begin
                foreach (m_tot[i]) m_tot[i] += int'(clicks[i]);
                if (m_t == G - 1) begin
                    if (was_empty) begin
                        for (int i = 0; i < N; i++) begin
                            w.ch   = i;
                            w.cnt  = (m_tot[i] > CNT_MAX) ? CNT_MAX : m_tot[i];
                            w.win  = m_win;
                            w.last = (i == N - 1) ? 1 : 0;
                            exp_q.push_back(w);
                        end
                        m_busy = N;
                    end else begin
                        m_drop = 1;
                    end
                    m_win = (m_win + 1) % 65536;
                    m_t   = 0;
                    foreach (m_tot[i]) m_tot[i] = 0;
                end else begin
                    m_t++;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            model_step();
        end
    end

    // Monitor: compares the presented word against the queue head, pops on handshake.
    task automatic mon_step();
        word_t w;
        check("out_valid", longint'(out_valid), (m_busy > 0) ? 1 : 0);
        check("dropped", longint'(dropped), m_drop);
        if (out_valid) begin
            check("pending_words", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                w = exp_q[0];
                check("word_channel", longint'(out_channel), w.ch);
                check("word_count", longint'(out_count), w.cnt);
                check("word_window", longint'(out_window), w.win);
                check("word_last", longint'(out_last), w.last);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            mon_step();
        end
    end

    task automatic step(input logic en, input logic [N-1:0] c, input logic r);
        enable    = en;
        clicks    = c;
        out_ready = r;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_t(input int target, input string name);
        int k = 0;
        while (m_t != target && k < 64) begin
            step(1'b1, 4'b0000, 1'b1);
            k++;
        end
        check(name, m_t, target);
    endtask

    task automatic wait_valid(input logic r, input string name);
        int k = 0;
        while (!out_valid && k < 200) begin
            step(1'b1, 4'($urandom), r);
            k++;
        end
        check(name, longint'(out_valid), 1);
    endtask

    initial begin
        int got;
        int k;
        reset_n   = 1'b1;
        enable    = 1'b0;
        clicks    = '0;
        out_ready = 1'b0;
        s_enable  = 1'b0;
        s_clicks  = 4'b0010;
        s_ready   = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_channel", longint'(out_channel), 0);
        check("rst_out_count", longint'(out_count), 0);
        check("rst_out_window", longint'(out_window), 0);
        check("rst_out_last", longint'(out_last), 0);
        check("rst_dropped", longint'(dropped), 0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Basic window: ch0 five clicks, ch2 every cycle.
        step(1'b1, 4'b0000, 1'b1);
        for (int i = 0; i < G; i++) step(1'b1, (i < 5) ? 4'b0101 : 4'b0100, 1'b1);
        repeat (8) step(1'b1, 4'b0000, 1'b1);

        // Click on the last timer cycle and on the first cycle of the next window.
        wait_t(G - 1, "wait_timer_last");
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0001, 1'b1);
        repeat (2 * G + 4) step(1'b1, 4'b0000, 1'b1);

        // Backpressure across several window ends.
        wait_valid(1'b0, "wait_first_snapshot");
        repeat (40) step(1'b1, 4'($urandom), 1'b0);
        check("dropped_after_stall", longint'(dropped), 1);
        repeat (80) step(1'b1, 4'($urandom), 1'b1);

        // Enable drop mid-window, then re-raise with ch3 clicking every cycle.
        wait_t(8, "wait_timer_8");
        repeat (3) step(1'b0, 4'b1000, 1'b1);
        repeat (60) step(1'b1, 4'b1000, 1'b1);

        // Reset in the middle of a drain.
        wait_valid(1'b0, "wait_drain_for_reset");
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        reset_n   = 1'b0;
        out_ready = 1'b0;
        #1;
        check("reset_mid_drain_valid", longint'(out_valid), 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (50) step(1'b1, 4'($urandom), 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 49) != 0), 4'($urandom), ($urandom_range(0, 3) != 0));
        end
        repeat (24) step(1'b0, 4'b0000, 1'b1);
        check("queue_drained", exp_q.size(), 0);

        // Saturation on the 4-bit, 32-cycle instance with ch1 held high.
        s_enable = 1'b1;
        got = 0;
        k   = 0;
        while (got < 4 && k < 200) begin
            @(negedge clock);
            k++;
            if (s_out_valid) begin
                check("sat_channel", longint'(s_out_channel), got);
                check("sat_count", longint'(s_out_count), (got == 1) ? 15 : 0);
                check("sat_window", longint'(s_out_window), 0);
                check("sat_last", longint'(s_out_last), (got == 3) ? 1 : 0);
                got++;
            end
        end
        check("sat_words", got, 4);
        check("sat_dropped", longint'(s_dropped), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
